pipelined_logic_alu: RTL
========================

// Module: pipelined_logic_alu
// PURPOSE
//  Registered, parametrised successor of the 8-function logic unit: same 3-bit opcode set,
//  widened to variable shifts, an accumulator operand mode and valid/ready flow control.
//  Two-stage pipeline; sits between an operand source (e.g. register file) and a result sink.
// PARAMETERS
//  N      8  datapath width in bits (N >= 2)
//  SHW    3  shift-amount width; shifts use shamt mod N (N a power of 2 recommended)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous, active-high reset
//  in_valid   in   1    operand beat valid
//  in_ready   out  1    unit can accept a beat this cycle
//  a          in   N    operand A
//  b          in   N    operand B (ignored when use_acc=1)
//  op         in   3    0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 SHL,7 SHR (logical)
//  shamt      in   SHW  shift amount for op 6/7
//  use_acc    in   1    operand B := accumulator
//  acc_we     in   1    write this beat's result into accumulator
//  out_valid  out  1    result valid
//  out_ready  in   1    sink accepts result
//  result     out  N    registered result
//  acc        out  N    current accumulator value
// BEHAVIOUR
//  - Reset (rst=1 at posedge): s1_valid=0, out_valid=0, result=0, acc=0; in_ready=1 on the first cycle after reset.
//    Reset mid-operation drops all in-flight beats; no partial result emerges.
//  - Stage 1 captures {a,b,op,shamt,use_acc,acc_we} on in_valid&&in_ready.
//  - Stage 2 computes from stage-1 regs and loads result when s2_load = s1_valid && (!out_valid || out_ready).
//  - out_valid set on s2_load; cleared on out_valid&&out_ready without s2_load.
//  - in_ready = !s1_valid || s2_load (combinational; full throughput, no bubbles).
//  - Latency: accept at edge k -> out_valid from edge k+1; result stable while out_valid && !out_ready.
//  - Op 6: result = a << (shamt % N); op 7: result = a >> (shamt % N); zero fill; bits shifted out are lost.
//    shamt=1 reproduces legacy x2 / /2.
//  - Accumulator: operand-B mux reads acc at stage-2 compute time; acc <= new result on s2_load when staged acc_we=1.
//    Back-to-back use_acc beats see the previous beat's write (no hazard, no stall).
//  - Simultaneous out handshake and new s2_load in one cycle: out_valid stays 1, result replaced.
//  - Backpressure: out_ready=0 with both stages full -> in_ready=0; no beat lost or duplicated.
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds outputs zero (1b, result==0) and msb_out (1b, bit shifted out on shift ops
//  with shamt%N!=0: a[N-shamt%N] for SHL, a[shamt%N-1] for SHR; else 0), registered with result; reset 0.
//  Undefined: flag ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams OP_AND..OP_SHR, OPW=3.
//  One sub-module: alu_logic_core (combinational N-bit function unit: a, b, op, shamt -> result).
//  Top holds stage regs, handshake control and accumulator.
// TESTING
//  1. N=8, rst then a=0xF0,b=0x3C, op 0..5 back-to-back, out_ready=1 -> 0x30,0xFC,0xCF,0x03,0xCC,0x33, one per cycle.
//  2. a=0x81, op6 shamt=1 -> 0x02; op7 shamt=1 -> 0x40; op6 shamt=0 -> 0x81; [FLAGS] msb_out=1,1,0.
//  3. acc_we=1 op1 a=0x0F,b=0 -> acc=0x0F; next use_acc op4 a=0xFF acc_we=1 -> result 0xF0, acc=0xF0.
//  4. out_ready=0 for 5 cycles with 4 beats offered -> exactly 2 accepted, result held; release -> in-order, no loss.
//  5. rst asserted while both stages full -> next cycle out_valid=0, acc=0, in_ready=1; no stale result.
//  6. Random valid/ready toggling, 1000 beats vs reference model -> all results match, order preserved.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings shared by the logic ALU and its function core
package alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_AND  = 3'd0;
  localparam logic [OPW-1:0] OP_OR   = 3'd1;
  localparam logic [OPW-1:0] OP_NAND = 3'd2;
  localparam logic [OPW-1:0] OP_NOR  = 3'd3;
  localparam logic [OPW-1:0] OP_XOR  = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR = 3'd5;
  localparam logic [OPW-1:0] OP_SHL  = 3'd6;
  localparam logic [OPW-1:0] OP_SHR  = 3'd7;

endpackage

// File: rtl/alu_logic_core.sv
// rtl/alu_logic_core.sv - combinational N-bit logic/shift function unit
// ALU_FLAGS_EN adds the shifted-out bit output (shout).
module alu_logic_core
  import alu_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = 3
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [OPW-1:0] op,
  input  logic [SHW-1:0] shamt,
  output logic [N-1:0]   result
`ifdef ALU_FLAGS_EN
  ,
  output logic           shout
`endif
);

  logic [31:0] sh;
  assign sh = 32'(shamt) % 32'(N);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_SHL:  result = a << sh;
      default: result = a >> sh;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Last bit to leave the word: a[N-sh] for SHL, a[sh-1] for SHR.
  logic [N-1:0] shl_lost;
  logic [N-1:0] shr_lost;
  assign shl_lost = a >> (32'(N) - sh);
  assign shr_lost = a >> (sh - 32'd1);

  always_comb begin
    shout = 1'b0;
    if (sh != 32'd0) begin
      if (op == OP_SHL) shout = shl_lost[0];
      else if (op == OP_SHR) shout = shr_lost[0];
    end
  end
`endif

endmodule

// File: rtl/pipelined_logic_alu.sv
// rtl/pipelined_logic_alu.sv - two-stage valid/ready logic ALU with accumulator operand
// ALU_FLAGS_EN adds registered zero and msb_out outputs.
module pipelined_logic_alu
  import alu_pkg::*;
#(
  parameter int N   = 8,
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [OPW-1:0] op,
  input  logic [SHW-1:0] shamt,
  input  logic           use_acc,
  input  logic           acc_we,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   result,
  output logic [N-1:0]   acc
`ifdef ALU_FLAGS_EN
  ,
  output logic           zero,
  output logic           msb_out
`endif
);

  logic           s1_valid;
  logic [N-1:0]   s1_a;
  logic [N-1:0]   s1_b;
  logic [OPW-1:0] s1_op;
  logic [SHW-1:0] s1_shamt;
  logic           s1_use_acc;
  logic           s1_acc_we;

  logic           s2_load;
  logic [N-1:0]   core_b;
  logic [N-1:0]   core_result;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  // acc is read at compute time, so a beat always sees the previous beat's write.
  assign core_b   = s1_use_acc ? acc : s1_b;

`ifdef ALU_FLAGS_EN
  logic core_shout;
`endif

  alu_logic_core #(.N(N), .SHW(SHW)) u_core (
    .a      (s1_a),
    .b      (core_b),
    .op     (s1_op),
    .shamt  (s1_shamt),
    .result (core_result)
`ifdef ALU_FLAGS_EN
    ,
    .shout  (core_shout)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      acc       <= '0;
`ifdef ALU_FLAGS_EN
      zero      <= 1'b0;
      msb_out   <= 1'b0;
`endif
    end else begin
      if (in_valid && in_ready) begin
        s1_valid   <= 1'b1;
        s1_a       <= a;
        s1_b       <= b;
        s1_op      <= op;
        s1_shamt   <= shamt;
        s1_use_acc <= use_acc;
        s1_acc_we  <= acc_we;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      if (s2_load) begin
        out_valid <= 1'b1;
        result    <= core_result;
        if (s1_acc_we) acc <= core_result;
`ifdef ALU_FLAGS_EN
        zero      <= (core_result == '0);
        msb_out   <= core_shout;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
